// File: rtl/display_bcd_sete_seg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sete_seg_pkg
// Description : Shared constants for the BCD 7-segment display stage:
//               active-high segment codes (bit order {g,f,e,d,c,b,a}),
//               BCD digit count and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sete_seg_pkg;

  // A 32-bit magnitude (up to 2^31) needs 10 decimal digits.
  localparam int c_bcd_digits = 10;

  // Active-high glyphs that are not decimal digits.
  localparam logic [6:0] c_seg_minus = 7'h40;
  localparam logic [6:0] c_seg_e     = 7'h79;
  localparam logic [6:0] c_seg_r     = 7'h50;
  localparam logic [6:0] c_seg_blank = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABS    = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_ENCODE = 2'd3
  } state_t;

  // Active-high segment pattern of one decimal digit.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h3F;
      4'd1:    seg_digit = 7'h06;
      4'd2:    seg_digit = 7'h5B;
      4'd3:    seg_digit = 7'h4F;
      4'd4:    seg_digit = 7'h66;
      4'd5:    seg_digit = 7'h6D;
      4'd6:    seg_digit = 7'h7D;
      4'd7:    seg_digit = 7'h07;
      4'd8:    seg_digit = 7'h7F;
      4'd9:    seg_digit = 7'h6F;
      default: seg_digit = c_seg_blank;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_bcd_sete_seg_if.sv
`default_nettype none
// ============================================================================
// Interface   : display_bcd_sete_seg_if
// Description : Request/result bundle between the register-file side (master)
//               and the 7-segment display stage (slave).
//   load      master->slave  convert request
//   data      master->slave  signed value to display
//   busy      slave->master  conversion in progress
//   done      slave->master  one-cycle pulse when the digits update
//   ovf       slave->master  last value did not fit, "Err" shown
//   dsp0..7   slave->master  segment patterns {g,f,e,d,c,b,a}, dsp0 = LSD
// Revision    : 1.0 - initial release
// ============================================================================
interface display_bcd_sete_seg_if #(
  parameter int DATA_W = 32
);
  logic              load;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [6:0]        dsp0, dsp1, dsp2, dsp3, dsp4, dsp5, dsp6, dsp7;

  modport master (
    output load, data,
    input  busy, done, ovf, dsp0, dsp1, dsp2, dsp3, dsp4, dsp5, dsp6, dsp7
  );

  modport slave (
    input  load, data,
    output busy, done, ovf, dsp0, dsp1, dsp2, dsp3, dsp4, dsp5, dsp6, dsp7
  );
endinterface
`default_nettype wire

// File: rtl/display_bcd_sete_seg_dabble.sv
`default_nettype none
// ============================================================================
// Module      : bin_bcd_dabble
// Description : Iterative two's-complement to BCD converter (shift-add-3).
//               start loads |value| and clears the BCD accumulator; each
//               step cycle performs one add-3/shift iteration. done is high
//               during the step cycle that performs the last iteration.
//   clk0   in   clock
//   reset  in   synchronous active-high reset
//   start  in   load magnitude, clear accumulator and iteration count
//   step   in   perform one iteration
//   value  in   signed input word
//   done   out  last iteration is being performed this cycle
//   bcd    out  packed BCD result, digit 0 in bits [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module bin_bcd_dabble
  import sete_seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_W  = 4 * c_bcd_digits
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] value,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Pre-shift correction: any nibble >= 5 would become >= 10 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      // Unsigned magnitude, so the most negative value maps to 2^(DATA_W-1).
      mag_d = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
      bcd_d = '0;
      cnt_d = '0;
    end else if (step) begin
      {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
      cnt_d          = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = step && (cnt_q == CNT_W'(DATA_W - 1));
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/display_bcd_sete_seg.sv
`default_nettype none
// ============================================================================
// Module      : display_bcd_sete_seg
// Description : Output stage driving eight 7-segment digits from a signed
//               word: iterative binary-to-BCD conversion, leading-zero
//               blanking, minus sign and "Err" overflow pattern.
//   clk0   in   board clock, sole clock of the block
//   reset  in   synchronous active-high reset
//   bus    slave modport: load/data in; busy/done/ovf/dsp0..dsp7 out
// Revision    : 1.0 - initial release
// ============================================================================
module display_bcd_sete_seg
  import sete_seg_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DIGITS         = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                    clk0,
  input logic                    reset,
  display_bcd_sete_seg_if.slave  bus
);

  localparam int         BCD_W       = 4 * c_bcd_digits;
  localparam logic [6:0] c_blank_out = SEG_ACTIVE_LOW ? ~c_seg_blank : c_seg_blank;

  function automatic logic [6:0] to_pins(input logic [6:0] code);
    return SEG_ACTIVE_LOW ? ~code : code;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [6:0]        dsp_q [DIGITS];
  logic [6:0]        dsp_d [DIGITS];

  logic              dab_start, dab_step, dab_done;
  logic [BCD_W-1:0]  bcd;

  logic              neg;
  logic              ovf_calc;
  int                msd;
  logic [6:0]        seg_code;
  logic [6:0]        dsp_next [DIGITS];

  bin_bcd_dabble #(
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W)
  ) u_dabble (
    .clk0  (clk0),
    .reset (reset),
    .start (dab_start),
    .step  (dab_step),
    .value (data_q),
    .done  (dab_done),
    .bcd   (bcd)
  );

  // Display formatting of the finished BCD word.
  always_comb begin
    neg      = data_q[DATA_W-1];
    // Digits beyond the display, or a full 8th digit with no room for '-'.
    ovf_calc = (|bcd[BCD_W-1:4*DIGITS]) | (neg & (|bcd[4*(DIGITS-1) +: 4]));
    msd      = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    seg_code = c_seg_blank;
    for (int i = 0; i < DIGITS; i++) begin
      seg_code = c_seg_blank;
      if (ovf_calc) begin
        if (i == 2)     seg_code = c_seg_e;
        else if (i < 2) seg_code = c_seg_r;
      end else if (i <= msd) begin
        seg_code = seg_digit(bcd[4*i +: 4]);
      end else if (neg && (i == msd + 1)) begin
        seg_code = c_seg_minus;
      end
      dsp_next[i] = to_pins(seg_code);
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    dsp_d     = dsp_q;
    dab_start = 1'b0;
    dab_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          data_d  = bus.data;
          state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        dab_start = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        dab_step = 1'b1;
        if (dab_done) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        dsp_d   = dsp_next;
        ovf_d   = ovf_calc;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) dsp_q[i] <= c_blank_out;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dsp_q   <= dsp_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.dsp0 = dsp_q[0];
  assign bus.dsp1 = dsp_q[1];
  assign bus.dsp2 = dsp_q[2];
  assign bus.dsp3 = dsp_q[3];
  assign bus.dsp4 = dsp_q[4];
  assign bus.dsp5 = dsp_q[5];
  assign bus.dsp6 = dsp_q[6];
  assign bus.dsp7 = dsp_q[7];

endmodule
`default_nettype wire

// File: tb/tb_display_bcd_sete_seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_bcd_sete_seg
// Description : Self-checking bench for display_bcd_sete_seg. Expected
//               displays come from a decimal-arithmetic model of the
//               display rules; directed and random values are applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_bcd_sete_seg;

  logic clk0;
  logic reset;
  int   n_cmp;
  int   n_bad;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

  display_bcd_sete_seg_if #(.DATA_W(32)) bus ();

  display_bcd_sete_seg #(
    .DATA_W         (32),
    .DIGITS         (8),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk0  (clk0),
    .reset (reset),
    .bus   (bus)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] obs_dsp();
    return {bus.dsp7, bus.dsp6, bus.dsp5, bus.dsp4,
            bus.dsp3, bus.dsp2, bus.dsp1, bus.dsp0};
  endfunction

  // Decimal reference: what the eight active-low digits should show for v.
  function automatic logic [55:0] model_dsp(input logic [31:0] v, output bit ovf);
    longint     m;
    longint     t;
    bit         neg;
    int         nd;
    logic [6:0] code [8];
    logic [55:0] r;
    neg = v[31];
    m   = longint'(v);
    if (neg) m = (longint'(1) << 32) - m;
    ovf = (m >= 100000000) || (neg && (m >= 10000000));
    for (int i = 0; i < 8; i++) code[i] = 7'h00;
    if (ovf) begin
      code[2] = 7'h79;
      code[1] = 7'h50;
      code[0] = 7'h50;
    end else begin
      nd = 0;
      t  = m;
      do begin
        nd++;
        t = t / 10;
      end while (t > 0);
      t = m;
      for (int i = 0; i < nd; i++) begin
        code[i] = SEG_TAB[int'(t % 10)];
        t = t / 10;
      end
      if (neg) code[nd] = 7'h40;
    end
    for (int i = 0; i < 8; i++) r[7*i +: 7] = ~code[i];
    return r;
  endfunction

  // Counts edges until done is seen; flags any edge where busy dropped early.
  task automatic wait_done(output int edges, output bit busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk0);
      #1;
      edges++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end while (!bus.done && edges < 80);
  endtask

  task automatic check_result(input string tag, input int edges, input bit busy_ok,
                              input logic [31:0] v);
    logic [55:0] exp_dsp;
    bit          exp_ovf;
    exp_dsp = model_dsp(v, exp_ovf);
    chk({tag, "_latency"}, 64'(edges), 64'd34);
    chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({tag, "_dsp"}, 64'(obs_dsp()), 64'(exp_dsp));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run_conv(input string tag, input logic [31:0] v);
    int edges;
    bit busy_ok;
    @(negedge clk0);
    bus.load = 1'b1;
    bus.data = v;
    @(posedge clk0);
    #1;
    chk({tag, "_busy_E0"}, 64'(bus.busy), 64'd1);
    @(negedge clk0);
    bus.load = 1'b0;
    bus.data = $urandom;
    wait_done(edges, busy_ok);
    check_result(tag, edges, busy_ok, v);
    @(posedge clk0);
    #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] edge_vals [8];
    int          edges;
    bit          busy_ok;
    bit          done_seen;

    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bus.load  = 1'b1;
    bus.data  = 32'd5;
    repeat (3) @(posedge clk0);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf",  64'(bus.ovf),  64'd0);
    chk("rst_dsp",  64'(obs_dsp()), 64'(ALL_BLANK));
    @(negedge clk0);
    bus.load = 1'b0;
    reset    = 1'b0;

    // Directed values, with literal display patterns for a few of them.
    run_conv("zero", 32'd0);
    chk("zero_lit", 64'(obs_dsp()), 64'({{7{7'h7F}}, 7'h40}));
    run_conv("12345678", 32'd12345678);
    chk("12345678_lit", 64'(obs_dsp()),
        64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    run_conv("minus1", 32'hFFFF_FFFF);
    chk("minus1_lit", 64'(obs_dsp()), 64'({{6{7'h7F}}, 7'h3F, 7'h79}));
    run_conv("min_int", 32'h8000_0000);
    chk("min_int_lit", 64'(obs_dsp()), 64'({{5{7'h7F}}, 7'h06, 7'h2F, 7'h2F}));
    run_conv("1e8", 32'd100000000);
    run_conv("neg1e7", -32'd10000000);
    run_conv("neg9999999", -32'd9999999);
    chk("neg9999999_minus", 64'(bus.dsp7), 64'h3F);
    run_conv("max_int", 32'h7FFF_FFFF);

    // A load while busy is ignored.
    va = 32'd4711;
    vb = 32'd90210;
    @(negedge clk0);
    bus.load = 1'b1;
    bus.data = va;
    @(posedge clk0);
    @(negedge clk0);
    bus.load = 1'b0;
    repeat (9) @(posedge clk0);
    @(negedge clk0);
    bus.load = 1'b1;
    bus.data = vb;
    @(posedge clk0);
    #1;
    @(negedge clk0);
    bus.load = 1'b0;
    wait_done(edges, busy_ok);
    check_result("ignored_load", edges + 10, busy_ok, va);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk0);
    bus.load = 1'b1;
    bus.data = -32'd321;
    @(posedge clk0);
    @(negedge clk0);
    bus.load = 1'b0;
    repeat (19) @(posedge clk0);
    @(negedge clk0);
    reset = 1'b1;
    @(posedge clk0);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_dsp", 64'(obs_dsp()), 64'(ALL_BLANK));
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk0);
    reset     = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk0);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_conv("after_abort", -32'd321);

    // Back-to-back with load held high.
    va = -32'd55;
    vb = 32'd7000001;
    @(negedge clk0);
    bus.load = 1'b1;
    bus.data = va;
    @(posedge clk0);
    @(negedge clk0);
    bus.data = vb;
    wait_done(edges, busy_ok);
    check_result("b2b_first", edges, busy_ok, va);
    @(posedge clk0);
    #1;
    chk("b2b_accept", 64'(bus.busy), 64'd1);
    @(negedge clk0);
    bus.load = 1'b0;
    wait_done(edges, busy_ok);
    check_result("b2b_second", edges, busy_ok, vb);

    // Random values, biased toward the interesting magnitude ranges.
    edge_vals = '{32'd99999999, 32'd100000000, -32'd9999999, -32'd10000000,
                  32'd9999999, 32'd10000000, 32'd9, -32'd10};
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: begin
          v = $urandom_range(0, 99999999);
          if ($urandom_range(0, 1) == 1) v = -v;
        end
        2: begin
          v = $urandom_range(0, 999);
          if ($urandom_range(0, 1) == 1) v = -v;
        end
        default: v = edge_vals[$urandom_range(0, 7)];
      endcase
      run_conv($sformatf("rand%0d_%0h", k, v), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
